// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store.
// Load/store has priority; a starvation counter forces a fetch grant after STARVE_MAX LSU wins.
module mem_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req_i,
   input  logic [63:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [63:0] lsu_addr_i,
   input  logic [63:0] lsu_wdata_i,
   input  logic [7:0]  lsu_wmask_i,
   output logic        lsu_gnt_o,
   output logic        lsu_rvalid_o,
   output logic [63:0] lsu_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [63:0] mem_addr_o,
   output logic [63:0] mem_wdata_o,
   output logic [7:0]  mem_wmask_o,
   input  logic        mem_ready_i,
   input  logic        mem_rvalid_i,
   input  logic [63:0] mem_rdata_i,
   output logic        busy_o
);

   localparam int unsigned CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_IF,
      WAIT_LSU
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] starve_cnt;
   logic          word_sel;
   logic          pick_if;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^if_addr_i[1:0];

   // Fetch wins when alone, or when it has been passed over STARVE_MAX times.
   assign pick_if = if_req_i && (!lsu_req_i || (starve_cnt == CNT_MAX));
   assign busy_o  = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_wmask_o = '0;
      if_gnt_o    = 1'b0;
      lsu_gnt_o   = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (if_req_i || lsu_req_i) begin
                  mem_req_o = 1'b1;
                  if (pick_if) begin
                     mem_addr_o = {if_addr_i[63:3], 3'b000};
                     if_gnt_o   = mem_ready_i;
                     if (mem_ready_i) begin
                        state_next = WAIT_IF;
                     end
                  end else begin
                     mem_we_o    = lsu_we_i;
                     mem_addr_o  = lsu_addr_i;
                     mem_wdata_o = lsu_wdata_i;
                     mem_wmask_o = lsu_we_i ? lsu_wmask_i : '0;
                     lsu_gnt_o   = mem_ready_i;
                     if (mem_ready_i) begin
                        state_next = WAIT_LSU;
                     end
                  end
               end
            end
            WAIT_IF: begin
               if (mem_rvalid_i) begin
                  state_next = IDLE;
               end
            end
            WAIT_LSU: begin
               if (mem_rvalid_i) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_cnt   <= '0;
         word_sel     <= 1'b0;
         if_rvalid_o  <= 1'b0;
         if_rdata_o   <= '0;
         lsu_rvalid_o <= 1'b0;
         lsu_rdata_o  <= '0;
      end else begin
         if_rvalid_o  <= 1'b0;
         lsu_rvalid_o <= 1'b0;
         if (if_gnt_o) begin
            word_sel   <= if_addr_i[2];
            starve_cnt <= '0;
         end
         if (lsu_gnt_o && if_req_i && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CW'(1);
         end
         // Responses only count while a transaction is owned; IDLE rvalids are stale.
         if (mem_rvalid_i && (state == WAIT_IF)) begin
            if_rvalid_o <= 1'b1;
            if_rdata_o  <= word_sel ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
         end
         if (mem_rvalid_i && (state == WAIT_LSU)) begin
            lsu_rvalid_o <= 1'b1;
            lsu_rdata_o  <= mem_rdata_i;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: expected responses are queued at grant
// time and compared when the owning rvalid pulse appears.
module tb_mem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req_i;
   logic [63:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [63:0] lsu_addr_i;
   logic [63:0] lsu_wdata_i;
   logic [7:0]  lsu_wmask_i;
   logic        lsu_gnt_o;
   logic        lsu_rvalid_o;
   logic [63:0] lsu_rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [63:0] mem_addr_o;
   logic [63:0] mem_wdata_o;
   logic [7:0]  mem_wmask_o;
   logic        mem_ready_i;
   logic        mem_rvalid_i;
   logic [63:0] mem_rdata_i;
   logic        busy_o;

   typedef struct {
      logic        owner_if;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   mem_port_arbiter #(.STARVE_MAX(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .if_req_i     (if_req_i),
      .if_addr_i    (if_addr_i),
      .if_gnt_o     (if_gnt_o),
      .if_rvalid_o  (if_rvalid_o),
      .if_rdata_o   (if_rdata_o),
      .lsu_req_i    (lsu_req_i),
      .lsu_we_i     (lsu_we_i),
      .lsu_addr_i   (lsu_addr_i),
      .lsu_wdata_i  (lsu_wdata_i),
      .lsu_wmask_i  (lsu_wmask_i),
      .lsu_gnt_o    (lsu_gnt_o),
      .lsu_rvalid_o (lsu_rvalid_o),
      .lsu_rdata_o  (lsu_rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_wmask_o  (mem_wmask_o),
      .mem_ready_i  (mem_ready_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .busy_o       (busy_o)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic respond(input logic [63:0] d);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = d;
      step();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      if_req_i    = 1'b1;
      lsu_req_i   = 1'b1;
      mem_ready_i = 1'b1;
      if_addr_i   = 64'h40;
      lsu_addr_i  = 64'h80;
      step();
      step();
      tests_run++;
      if (mem_req_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mem_req: got %b expected 0", mem_req_o);
      end
      tests_run++;
      if ({if_gnt_o, lsu_gnt_o} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_gnt: got %b expected 00", {if_gnt_o, lsu_gnt_o});
      end
      tests_run++;
      if (mem_addr_o !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset_mem_addr: got %h expected 0", mem_addr_o);
      end
      tests_run++;
      if ({if_rvalid_o, lsu_rvalid_o, busy_o} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_valid_busy: got %b expected 000", {if_rvalid_o, lsu_rvalid_o, busy_o});
      end
      tests_run++;
      if ((if_rdata_o !== 32'h0) || (lsu_rdata_o !== 64'h0)) begin
         tests_failed++;
         $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata_o, lsu_rdata_o);
      end
      tests_run++;
      if (dut.starve_cnt !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_starve: got %0d expected 0", dut.starve_cnt);
      end
      if_req_i  = 1'b0;
      lsu_req_i = 1'b0;
      reset     = 1'b0;
      step();
   endtask

   task automatic test_fetch();
      exp_t e;
      if_req_i    = 1'b1;
      if_addr_i   = 64'h8000_0004;
      mem_ready_i = 1'b1;
      #1;
      tests_run++;
      if ({mem_req_o, if_gnt_o, lsu_gnt_o} !== 3'b110) begin
         tests_failed++;
         $display("FAIL fetch_grant: got req/if/lsu=%b expected 110", {mem_req_o, if_gnt_o, lsu_gnt_o});
      end
      tests_run++;
      if (mem_addr_o !== 64'h8000_0000) begin
         tests_failed++;
         $display("FAIL fetch_addr: got %h expected 80000000", mem_addr_o);
      end
      tests_run++;
      if ({mem_we_o, mem_wmask_o, mem_wdata_o} !== 73'h0) begin
         tests_failed++;
         $display("FAIL fetch_cmd: got we=%b mask=%h wdata=%h expected zeros", mem_we_o, mem_wmask_o, mem_wdata_o);
      end
      sb.push_back('{owner_if: 1'b1, data: 64'h0000_0000_1111_2222});
      step();
      if_req_i = 1'b0;
      #1;
      tests_run++;
      if ({if_gnt_o, mem_req_o, busy_o} !== 3'b001) begin
         tests_failed++;
         $display("FAIL fetch_wait: got gnt/req/busy=%b expected 001", {if_gnt_o, mem_req_o, busy_o});
      end
      step();
      tests_run++;
      if (if_rvalid_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL fetch_early_rvalid: got %b expected 0", if_rvalid_o);
      end
      respond(64'h1111_2222_3333_4444);
      e = sb.pop_front();
      tests_run++;
      if ({if_rvalid_o, lsu_rvalid_o} !== 2'b10 || if_rdata_o !== e.data[31:0]) begin
         tests_failed++;
         $display("FAIL fetch_resp: got rv=%b data=%h expected rv=10 data=%h", {if_rvalid_o, lsu_rvalid_o}, if_rdata_o, e.data[31:0]);
      end
      tests_run++;
      if (busy_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL fetch_idle: got busy=%b expected 0", busy_o);
      end
      step();
      tests_run++;
      if (if_rvalid_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL fetch_pulse: got %b expected 0", if_rvalid_o);
      end
   endtask

   task automatic test_priority();
      exp_t e;
      if_req_i    = 1'b1;
      if_addr_i   = 64'h100;
      lsu_req_i   = 1'b1;
      lsu_we_i    = 1'b0;
      lsu_addr_i  = 64'h1000;
      lsu_wdata_i = 64'h5555;
      lsu_wmask_i = 8'hFF;
      mem_ready_i = 1'b1;
      #1;
      tests_run++;
      if ({lsu_gnt_o, if_gnt_o} !== 2'b10) begin
         tests_failed++;
         $display("FAIL prio_gnt: got lsu/if=%b expected 10", {lsu_gnt_o, if_gnt_o});
      end
      tests_run++;
      if (mem_addr_o !== 64'h1000 || mem_wmask_o !== 8'h00 || mem_we_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL prio_load_cmd: got addr=%h mask=%h we=%b expected 1000/00/0", mem_addr_o, mem_wmask_o, mem_we_o);
      end
      sb.push_back('{owner_if: 1'b0, data: 64'hA5A5_0000_5A5A_FFFF});
      step();
      lsu_req_i = 1'b0;
      #1;
      tests_run++;
      if (dut.starve_cnt !== 3'd1) begin
         tests_failed++;
         $display("FAIL prio_starve_inc: got %0d expected 1", dut.starve_cnt);
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'hA5A5_0000_5A5A_FFFF;
      #1;
      tests_run++;
      if (if_gnt_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL prio_no_arb_in_rvalid: got %b expected 0", if_gnt_o);
      end
      step();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      #1;
      e = sb.pop_front();
      tests_run++;
      if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== e.data || if_rvalid_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL prio_lsu_resp: got rv=%b data=%h expected 1/%h", lsu_rvalid_o, lsu_rdata_o, e.data);
      end
      tests_run++;
      if (if_gnt_o !== 1'b1 || mem_addr_o !== 64'h100) begin
         tests_failed++;
         $display("FAIL prio_fetch_next: got gnt=%b addr=%h expected 1/100", if_gnt_o, mem_addr_o);
      end
      sb.push_back('{owner_if: 1'b1, data: 64'h0000_0000_CAFE_F00D});
      step();
      if_req_i = 1'b0;
      respond(64'h1234_5678_CAFE_F00D);
      e = sb.pop_front();
      tests_run++;
      if (if_rvalid_o !== 1'b1 || if_rdata_o !== e.data[31:0]) begin
         tests_failed++;
         $display("FAIL prio_fetch_resp: got rv=%b data=%h expected 1/%h", if_rvalid_o, if_rdata_o, e.data[31:0]);
      end
      tests_run++;
      if (dut.starve_cnt !== 3'd0) begin
         tests_failed++;
         $display("FAIL prio_starve_clear: got %0d expected 0", dut.starve_cnt);
      end
   endtask

   task automatic test_starvation();
      exp_t        e;
      logic [63:0] d;
      if_req_i    = 1'b1;
      if_addr_i   = 64'h204;
      lsu_req_i   = 1'b1;
      lsu_we_i    = 1'b0;
      lsu_addr_i  = 64'h3300;
      mem_ready_i = 1'b1;
      for (int g = 0; g < 5; g++) begin
         #1;
         tests_run++;
         if (int'(dut.starve_cnt) !== g) begin
            tests_failed++;
            $display("FAIL starve_cnt_%0d: got %0d expected %0d", g, dut.starve_cnt, g);
         end
         tests_run++;
         if ({lsu_gnt_o, if_gnt_o} !== ((g < 4) ? 2'b10 : 2'b01)) begin
            tests_failed++;
            $display("FAIL starve_gnt_%0d: got lsu/if=%b expected %b", g, {lsu_gnt_o, if_gnt_o}, (g < 4) ? 2'b10 : 2'b01);
         end
         d = {32'hAB00_0000 | 32'(g), 32'hCD00_0000 | 32'(g)};
         if (g < 4) sb.push_back('{owner_if: 1'b0, data: d});
         else       sb.push_back('{owner_if: 1'b1, data: {32'h0, d[63:32]}});
         step();
         respond(d);
         e = sb.pop_front();
         tests_run++;
         if (e.owner_if ? (if_rvalid_o !== 1'b1 || lsu_rvalid_o !== 1'b0 || if_rdata_o !== e.data[31:0])
                        : (lsu_rvalid_o !== 1'b1 || if_rvalid_o !== 1'b0 || lsu_rdata_o !== e.data)) begin
            tests_failed++;
            $display("FAIL starve_resp_%0d: got rv if/lsu=%b%b data=%h/%h expected owner_if=%b data=%h",
                     g, if_rvalid_o, lsu_rvalid_o, if_rdata_o, lsu_rdata_o, e.owner_if, e.data);
         end
      end
      if_req_i  = 1'b0;
      lsu_req_i = 1'b0;
      #1;
      tests_run++;
      if (dut.starve_cnt !== 3'd0) begin
         tests_failed++;
         $display("FAIL starve_after_fetch: got %0d expected 0", dut.starve_cnt);
      end
      step();
   endtask

   task automatic test_store();
      exp_t e;
      if_req_i    = 1'b0;
      lsu_req_i   = 1'b1;
      lsu_we_i    = 1'b1;
      lsu_addr_i  = 64'h2008;
      lsu_wdata_i = 64'hDEAD_BEEF;
      lsu_wmask_i = 8'h0F;
      mem_ready_i = 1'b1;
      #1;
      tests_run++;
      if ({lsu_gnt_o, mem_we_o} !== 2'b11 || mem_wmask_o !== 8'h0F || mem_addr_o !== 64'h2008 || mem_wdata_o !== 64'hDEAD_BEEF) begin
         tests_failed++;
         $display("FAIL store_cmd: got gnt/we=%b mask=%h addr=%h wdata=%h expected 11/0f/2008/deadbeef",
                  {lsu_gnt_o, mem_we_o}, mem_wmask_o, mem_addr_o, mem_wdata_o);
      end
      sb.push_back('{owner_if: 1'b0, data: 64'h0});
      step();
      lsu_req_i = 1'b0;
      lsu_we_i  = 1'b0;
      tests_run++;
      if (dut.starve_cnt !== 3'd0) begin
         tests_failed++;
         $display("FAIL store_starve_hold: got %0d expected 0", dut.starve_cnt);
      end
      respond(64'h0);
      e = sb.pop_front();
      tests_run++;
      if (lsu_rvalid_o !== 1'b1 || if_rvalid_o !== 1'b0 || lsu_rdata_o !== e.data) begin
         tests_failed++;
         $display("FAIL store_ack: got lsu/if rv=%b%b data=%h expected 10/%h", lsu_rvalid_o, if_rvalid_o, lsu_rdata_o, e.data);
      end
      step();
      tests_run++;
      if ({lsu_rvalid_o, if_rvalid_o} !== 2'b00) begin
         tests_failed++;
         $display("FAIL store_pulse: got %b expected 00", {lsu_rvalid_o, if_rvalid_o});
      end
   endtask

   task automatic test_reset_mid();
      if_req_i    = 1'b1;
      if_addr_i   = 64'h500;
      lsu_req_i   = 1'b1;
      lsu_we_i    = 1'b0;
      lsu_addr_i  = 64'h4000;
      mem_ready_i = 1'b1;
      #1;
      tests_run++;
      if (lsu_gnt_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL rstmid_gnt: got %b expected 1", lsu_gnt_o);
      end
      sb.push_back('{owner_if: 1'b0, data: 64'h7777});
      step();
      if_req_i  = 1'b0;
      lsu_req_i = 1'b0;
      reset     = 1'b1;
      #1;
      tests_run++;
      if (busy_o !== 1'b1 || mem_req_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_wait: got busy=%b req=%b expected 1/0", busy_o, mem_req_o);
      end
      step();
      reset = 1'b0;
      sb.delete();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'h7777;
      #1;
      tests_run++;
      if (busy_o !== 1'b0 || dut.starve_cnt !== 3'd0) begin
         tests_failed++;
         $display("FAIL rstmid_state: got busy=%b starve=%0d expected 0/0", busy_o, dut.starve_cnt);
      end
      step();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      tests_run++;
      if ({lsu_rvalid_o, if_rvalid_o} !== 2'b00 || lsu_rdata_o !== 64'h0 || busy_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_drop: got rv=%b data=%h busy=%b expected 00/0/0", {lsu_rvalid_o, if_rvalid_o}, lsu_rdata_o, busy_o);
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      lsu_req_i   = 1'b1;
      lsu_we_i    = 1'b0;
      lsu_addr_i  = 64'h3000;
      lsu_wmask_i = 8'h00;
      mem_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests_run++;
         if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h3000 || lsu_gnt_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_stall_%0d: got req=%b addr=%h gnt=%b expected 1/3000/0", c, mem_req_o, mem_addr_o, lsu_gnt_o);
         end
         step();
         tests_run++;
         if (busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_busy_%0d: got %b expected 0", c, busy_o);
         end
      end
      mem_ready_i = 1'b1;
      #1;
      tests_run++;
      if (lsu_gnt_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_gnt: got %b expected 1", lsu_gnt_o);
      end
      sb.push_back('{owner_if: 1'b0, data: 64'h0BAD_F00D_1234_0001});
      step();
      lsu_req_i = 1'b0;
      #1;
      tests_run++;
      if (lsu_gnt_o !== 1'b0 || busy_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_single_gnt: got gnt=%b busy=%b expected 0/1", lsu_gnt_o, busy_o);
      end
      respond(64'h0BAD_F00D_1234_0001);
      e = sb.pop_front();
      tests_run++;
      if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== e.data) begin
         tests_failed++;
         $display("FAIL bp_resp: got rv=%b data=%h expected 1/%h", lsu_rvalid_o, lsu_rdata_o, e.data);
      end
   endtask

   initial begin
      reset        = 1'b1;
      if_req_i     = 1'b0;
      if_addr_i    = '0;
      lsu_req_i    = 1'b0;
      lsu_we_i     = 1'b0;
      lsu_addr_i   = '0;
      lsu_wdata_i  = '0;
      lsu_wmask_i  = '0;
      mem_ready_i  = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      test_reset();
      test_fetch();
      test_priority();
      test_starvation();
      test_store();
      test_reset_mid();
      test_backpressure();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
